// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports and one write port, R0 hardwired to 0.
// Defining REGISTER_FILE_BYPASS_EN forwards write data to same-index reads in the write cycle.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en;

    assign wr_en = WriteReg && (DstReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[DstReg] = DstData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reset and index 0 take priority over both storage and bypass.
    always_comb begin
        SrcData1 = '0;
        SrcData2 = '0;
        if (!rst) begin
            if (SrcReg1 != '0) begin
                SrcData1 = regs_q[SrcReg1];
`ifdef REGISTER_FILE_BYPASS_EN
                if (wr_en && (DstReg == SrcReg1)) begin
                    SrcData1 = DstData;
                end
`endif
            end
            if (SrcReg2 != '0) begin
                SrcData2 = regs_q[SrcReg2];
`ifdef REGISTER_FILE_BYPASS_EN
                if (wr_en && (DstReg == SrcReg2)) begin
                    SrcData2 = DstData;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file; expectations follow REGISTER_FILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  SrcReg1, SrcReg2, DstReg;
    logic        WriteReg;
    logic [15:0] DstData;
    logic [15:0] SrcData1, SrcData2;

    int checks = 0;
    int errors = 0;

    register_file #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .SrcReg1  (SrcReg1),
        .SrcReg2  (SrcReg2),
        .DstReg   (DstReg),
        .WriteReg (WriteReg),
        .DstData  (DstData),
        .SrcData1 (SrcData1),
        .SrcData2 (SrcData2)
    );

    always #5 clk = ~clk;

`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        WriteReg = 1'b1;
        DstReg   = a;
        DstData  = d;
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_byp;
        rst = 1'b1;
        SrcReg1 = 4'd5;
        SrcReg2 = 4'd9;
        DstReg = '0;
        WriteReg = 1'b0;
        DstData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd1", SrcData1, 16'h0000);
        check("rst_rd2", SrcData2, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset clears a preloaded register mid-cycle.
        write_reg(4'd5, 16'hBEEF);
        SrcReg1 = 4'd5;
        #1;
        check("preload_r5", SrcData1, 16'hBEEF);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_r5", SrcData1, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            SrcReg1 = 4'(i);
            SrcReg2 = 4'(15 - i);
            #1;
            check($sformatf("clr_p1_r%0d", i), SrcData1, 16'h0000);
            check($sformatf("clr_p2_r%0d", 15 - i), SrcData2, 16'h0000);
        end

        // Basic write and dual-port same-index read.
        write_reg(4'd3, 16'h1234);
        SrcReg1 = 4'd3;
        SrcReg2 = 4'd3;
        #1;
        check("wr_r3_p1", SrcData1, 16'h1234);
        check("wr_r3_p2", SrcData2, 16'h1234);
        SrcReg1 = 4'd2;
        SrcReg2 = 4'd4;
        #1;
        check("r2_zero", SrcData1, 16'h0000);
        check("r4_zero", SrcData2, 16'h0000);

        // R0 stays zero even while written.
        @(negedge clk);
        WriteReg = 1'b1;
        DstReg = 4'd0;
        DstData = 16'hFFFF;
        SrcReg1 = 4'd0;
        SrcReg2 = 4'd0;
        #1;
        check("r0_same_p1", SrcData1, 16'h0000);
        check("r0_same_p2", SrcData2, 16'h0000);
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        #1;
        check("r0_next", SrcData1, 16'h0000);

        // Write-cycle read of the target register.
        write_reg(4'd7, 16'h00AA);
        @(negedge clk);
        WriteReg = 1'b1;
        DstReg = 4'd7;
        DstData = 16'h5555;
        SrcReg1 = 4'd7;
        SrcReg2 = 4'd7;
        exp_byp = BYP ? 16'h5555 : 16'h00AA;
        #1;
        check("byp_same_p1", SrcData1, exp_byp);
        check("byp_same_p2", SrcData2, exp_byp);
        SrcReg1 = 4'd3;
        #1;
        check("byp_other_p1", SrcData1, 16'h1234);
        check("byp_keep_p2", SrcData2, exp_byp);
        @(posedge clk);
        #1;
        WriteReg = 1'b0;
        #1;
        check("byp_next_p2", SrcData2, 16'h5555);

        // WriteReg low holds the register across several edges.
        write_reg(4'd9, 16'h0042);
        @(negedge clk);
        WriteReg = 1'b0;
        DstReg = 4'd9;
        DstData = 16'hDEAD;
        SrcReg1 = 4'd9;
        repeat (4) @(posedge clk);
        #1;
        check("hold_r9", SrcData1, 16'h0042);

        // Reset coinciding with a write edge discards the write.
        @(negedge clk);
        WriteReg = 1'b1;
        DstReg = 4'd12;
        DstData = 16'h7777;
        rst = 1'b1;
        SrcReg1 = 4'd12;
        @(posedge clk);
        #1;
        check("rstwr_during", SrcData1, 16'h0000);
        @(negedge clk);
        WriteReg = 1'b0;
        rst = 1'b0;
        #1;
        check("rstwr_r12", SrcData1, 16'h0000);
        SrcReg2 = 4'd9;
        #1;
        check("rstwr_r9_clr", SrcData2, 16'h0000);
        write_reg(4'd12, 16'h7777);
        #1;
        check("r12_after", SrcData1, 16'h7777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register and data-port width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: register-index width; register count is 2**ADDR_W (16).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port SrcReg1, input, ADDR_W: read-port-1 register index.
REQ-006 SHALL have port SrcReg2, input, ADDR_W: read-port-2 register index.
REQ-007 SHALL have port DstReg, input, ADDR_W: write-port register index.
REQ-008 SHALL have port WriteReg, input, 1: write enable, active-high.
REQ-009 SHALL have port DstData, input, DATA_W: write data.
REQ-010 SHALL have port SrcData1, output, DATA_W: read-port-1 data; feeds the shifter and ALU operand A.
REQ-011 SHALL have port SrcData2, output, DATA_W: read-port-2 data; feeds ALU operand B and store data.

Function
REQ-012 SHALL hold 16 registers R0-R15 of DATA_W bits each.
REQ-013 SHALL write DstData into R[DstReg] on the rising clk edge when WriteReg=1, rst=0 and DstReg!=0.
REQ-014 SHALL leave every register unchanged on a rising edge when WriteReg=0.
REQ-015 SHALL keep R0 at 0 at all times: writes to DstReg=0 are discarded, and reads of index 0 return 0.
REQ-016 SHALL read combinationally, with zero-cycle latency: SrcData1=R[SrcReg1] and SrcData2=R[SrcReg2], updating within the same cycle that the index changes.
REQ-017 SHALL allow both read ports to address the same register at once; both ports then return identical data.
REQ-018 SHALL perform at most one write per cycle; a write becomes visible to non-bypassed reads in the cycle after the write edge.
REQ-019 SHALL NOT alter any register when the write index is X-free but WriteReg is X; the bench treats this case as illegal stimulus.
REQ-020 SHALL apply read/write same-index behaviour (write active, DstReg equal to a read index, index !=0) per the Configuration section.

Reset
REQ-021 SHALL clear R0-R15 to 16'h0000 immediately on rst assertion, without waiting for a clock edge.
REQ-022 SHALL hold all registers at 0 while rst=1 and ignore WriteReg during that time.
REQ-023 SHALL drive SrcData1 and SrcData2 to 16'h0000 while rst=1, for any index.
REQ-024 SHALL discard an in-flight write whose edge coincides with rst=1; after rst deasserts, the first rising edge with WriteReg=1 performs a normal write.

Configuration
REQ-025 SHALL use macro REGISTER_FILE_BYPASS_EN to control write-to-read bypass.
REQ-026 With REGISTER_FILE_BYPASS_EN defined, a read port whose index equals DstReg (!=0) while WriteReg=1 SHALL output DstData combinationally in the same cycle; both ports bypass independently.
REQ-027 Without REGISTER_FILE_BYPASS_EN, reads SHALL always return the stored value, so the old value is seen in the write cycle and the new value in the next cycle.
REQ-028 SHALL keep R0 reads at 0 in both configurations, even when bypass is enabled and DstReg=0.

Verification
REQ-029 Reset: preload R5=16'hBEEF, assert rst mid-cycle -> SrcData1 (SrcReg1=5) reads 16'h0000 before the next edge; all 16 registers read 0.
REQ-030 Write/read: WriteReg=1, DstReg=3, DstData=16'h1234 for one edge -> next cycle SrcReg1=3 and SrcReg2=3 both read 16'h1234; R2 and R4 are still 0.
REQ-031 R0: WriteReg=1, DstReg=0, DstData=16'hFFFF -> SrcData1 (SrcReg1=0) reads 16'h0000 in the same cycle and the next, in both configurations.
REQ-032 Bypass: R7=16'h00AA, then WriteReg=1, DstReg=7, DstData=16'h5555, SrcReg2=7 -> same cycle reads 16'h5555 with REGISTER_FILE_BYPASS_EN, 16'h00AA without; next cycle reads 16'h5555 in both.
REQ-033 Hold: WriteReg=0, DstReg=9, DstData=16'hDEAD for 4 edges -> R9 is unchanged at its prior value 16'h0042.
REQ-034 Reset vs write: rst rises in the same cycle as WriteReg=1, DstReg=12, DstData=16'h7777 -> R12=0 after rst deasserts; a later write of 16'h7777 lands normally.
